trap_ctrl: RTL and testbench

//  Trap/return sequencer between pipeline exception detectors and csrs. Picks one trap

---
 rtl/trap_ctrl.sv | 111 +++++++++++
 tb/tb_trap_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/trap_ctrl.sv
// Trap/return sequencer: arbitrates one exception or mret per event, strobes the csrs,
// redirects fetch to the trap vector or mepc and holds a fixed-length pipeline flush.
module trap_ctrl #(
    parameter int          FLUSH_CYCLES = 3,
    parameter logic [31:0] RESET_PC     = 32'h0001_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        misalign_req,
    input  logic [31:0] misalign_pc,
    input  logic [31:0] misalign_tgt,
    input  logic        illegal_req,
    input  logic        ecall_req,
    input  logic        mret_req,
    input  logic [31:0] id_pc,
    input  logic [31:0] id_ir,
    input  logic [31:0] trap_vector_addr,
    input  logic [31:0] mepc_in,
    output logic        e_raised,
    output logic [1:0]  e_cause,
    output logic [31:0] e_pc,
    output logic [31:0] e_tval,
    output logic        is_mret,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        flush
);

    localparam logic [1:0] I_ADDR_MISALIGNMENT = 2'd0;
    localparam logic [1:0] ILLEGAL_IR          = 2'd1;
    localparam logic [1:0] ECALL               = 2'd2;

    localparam logic [3:0] COUNT_LOAD = 4'(FLUSH_CYCLES - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t     state;
    logic [3:0] count;
    logic       any_req;

    assign any_req = misalign_req | illegal_req | ecall_req | mret_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            count          <= 4'd0;
            e_raised       <= 1'b0;
            e_cause        <= 2'd0;
            e_pc           <= 32'd0;
            e_tval         <= 32'd0;
            is_mret        <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= RESET_PC;
            flush          <= 1'b0;
        end else begin
            e_raised       <= 1'b0;
            is_mret        <= 1'b0;
            redirect_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state          <= FLUSH;
                        flush          <= 1'b1;
                        redirect_valid <= 1'b1;
                        count          <= COUNT_LOAD;
                        // EX is older than ID, so a misaligned target beats any ID event.
                        if (misalign_req) begin
                            e_raised    <= 1'b1;
                            e_cause     <= I_ADDR_MISALIGNMENT;
                            e_pc        <= misalign_pc;
                            e_tval      <= misalign_tgt;
                            redirect_pc <= trap_vector_addr;
                        end else if (illegal_req) begin
                            e_raised    <= 1'b1;
                            e_cause     <= ILLEGAL_IR;
                            e_pc        <= id_pc;
                            e_tval      <= id_ir;
                            redirect_pc <= trap_vector_addr;
                        end else if (ecall_req) begin
                            e_raised    <= 1'b1;
                            e_cause     <= ECALL;
                            e_pc        <= id_pc;
                            e_tval      <= 32'd0;
                            redirect_pc <= trap_vector_addr;
                        end else begin
                            is_mret     <= 1'b1;
                            redirect_pc <= mepc_in;
                        end
                    end
                end
                FLUSH: begin
                    // Requests seen here belong to flushed instructions and will re-fetch.
                    if (count == 4'd0) begin
                        state <= IDLE;
                        flush <= 1'b0;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    flush <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: reset, trap sources, priority, mret, flush window, reset abort.
module tb_trap_ctrl;

    localparam logic [1:0] C_MISALIGN = 2'd0;
    localparam logic [1:0] C_ILLEGAL  = 2'd1;
    localparam logic [1:0] C_ECALL    = 2'd2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        misalign_req, illegal_req, ecall_req, mret_req;
    logic [31:0] misalign_pc, misalign_tgt, id_pc, id_ir, trap_vector_addr, mepc_in;
    logic        e_raised, is_mret, redirect_valid, flush;
    logic [1:0]  e_cause;
    logic [31:0] e_pc, e_tval, redirect_pc;

    int pass_cnt = 0;
    int total    = 0;

    trap_ctrl #(.FLUSH_CYCLES(3), .RESET_PC(32'h0001_0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .misalign_req(misalign_req), .misalign_pc(misalign_pc), .misalign_tgt(misalign_tgt),
        .illegal_req(illegal_req), .ecall_req(ecall_req), .mret_req(mret_req),
        .id_pc(id_pc), .id_ir(id_ir), .trap_vector_addr(trap_vector_addr), .mepc_in(mepc_in),
        .e_raised(e_raised), .e_cause(e_cause), .e_pc(e_pc), .e_tval(e_tval),
        .is_mret(is_mret), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .flush(flush)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        misalign_req = 1'b0;
        illegal_req  = 1'b0;
        ecall_req    = 1'b0;
        mret_req     = 1'b0;
    endtask

    // Checks flush is high in the remaining FLUSH cycles and drops afterwards.
    task automatic check_flush_tail(input string name);
        for (int i = 0; i < 2; i++) begin
            step();
            total++;
            if (flush !== 1'b1 || e_raised !== 1'b0 || is_mret !== 1'b0 || redirect_valid !== 1'b0)
                $display("FAIL %s_hold%0d flush=%b e_raised=%b is_mret=%b rv=%b required 1,0,0,0",
                         name, i, flush, e_raised, is_mret, redirect_valid);
            else pass_cnt++;
        end
        step();
        total++;
        if (flush !== 1'b0) $display("FAIL %s_drop flush=%b required 0", name, flush);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        clear_reqs();
        misalign_pc = 0; misalign_tgt = 0; id_pc = 0; id_ir = 0;
        trap_vector_addr = 0; mepc_in = 0;
        rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            total++;
            if ({e_raised, is_mret, redirect_valid, flush} !== 4'b0000 ||
                redirect_pc !== 32'h0001_0000 || e_cause !== 2'd0 || e_pc !== 32'd0 || e_tval !== 32'd0)
                $display("FAIL reset%0d strobes=%b rpc=%h cause=%0d pc=%h tval=%h required 0000 00010000 0 0 0",
                         i, {e_raised, is_mret, redirect_valid, flush}, redirect_pc, e_cause, e_pc, e_tval);
            else pass_cnt++;
        end
    endtask

    task automatic test_illegal();
        illegal_req = 1'b1; id_pc = 32'h0001_0040; id_ir = 32'hFFFF_FFFF;
        trap_vector_addr = 32'h0000_0100;
        step();
        clear_reqs();
        total++;
        if (e_raised !== 1'b1 || e_cause !== C_ILLEGAL || e_pc !== 32'h0001_0040 ||
            e_tval !== 32'hFFFF_FFFF || redirect_pc !== 32'h0000_0100 ||
            redirect_valid !== 1'b1 || flush !== 1'b1 || is_mret !== 1'b0)
            $display("FAIL illegal er=%b cause=%0d pc=%h tval=%h rpc=%h rv=%b fl=%b mret=%b required 1 1 00010040 ffffffff 00000100 1 1 0",
                     e_raised, e_cause, e_pc, e_tval, redirect_pc, redirect_valid, flush, is_mret);
        else pass_cnt++;
        check_flush_tail("illegal");
        total++;
        if (e_cause !== C_ILLEGAL || e_pc !== 32'h0001_0040 || redirect_pc !== 32'h0000_0100)
            $display("FAIL illegal_hold cause=%0d pc=%h rpc=%h required 1 00010040 00000100",
                     e_cause, e_pc, redirect_pc);
        else pass_cnt++;
    endtask

    task automatic test_priority();
        misalign_req = 1'b1; misalign_pc = 32'h0001_0020; misalign_tgt = 32'h0001_0032;
        ecall_req = 1'b1; illegal_req = 1'b1; mret_req = 1'b1; id_pc = 32'h0001_0024;
        trap_vector_addr = 32'h0000_0200;
        step();
        clear_reqs();
        total++;
        if (e_raised !== 1'b1 || e_cause !== C_MISALIGN || e_pc !== 32'h0001_0020 ||
            e_tval !== 32'h0001_0032 || redirect_pc !== 32'h0000_0200 || is_mret !== 1'b0)
            $display("FAIL misalign_prio er=%b cause=%0d pc=%h tval=%h rpc=%h mret=%b required 1 0 00010020 00010032 00000200 0",
                     e_raised, e_cause, e_pc, e_tval, redirect_pc, is_mret);
        else pass_cnt++;
        check_flush_tail("misalign");
        // Dropped ecall must not appear after the flush window either.
        step();
        total++;
        if (e_raised !== 1'b0 || flush !== 1'b0)
            $display("FAIL ecall_dropped er=%b fl=%b required 0 0", e_raised, flush);
        else pass_cnt++;
        // ecall beats mret when both are raised by ID.
        ecall_req = 1'b1; mret_req = 1'b1; id_pc = 32'h0001_0060; mepc_in = 32'h0001_0abc;
        step();
        clear_reqs();
        total++;
        if (e_raised !== 1'b1 || is_mret !== 1'b0 || e_cause !== C_ECALL ||
            e_pc !== 32'h0001_0060 || e_tval !== 32'd0 || redirect_pc !== 32'h0000_0200)
            $display("FAIL ecall_over_mret er=%b mret=%b cause=%0d pc=%h tval=%h rpc=%h required 1 0 2 00010060 0 00000200",
                     e_raised, is_mret, e_cause, e_pc, e_tval, redirect_pc);
        else pass_cnt++;
        check_flush_tail("ecall_prio");
    endtask

    task automatic test_mret();
        mret_req = 1'b1; mepc_in = 32'h0001_0044;
        step();
        clear_reqs();
        total++;
        if (is_mret !== 1'b1 || e_raised !== 1'b0 || redirect_valid !== 1'b1 ||
            redirect_pc !== 32'h0001_0044 || flush !== 1'b1 || e_cause !== C_ECALL || e_pc !== 32'h0001_0060)
            $display("FAIL mret mret=%b er=%b rv=%b rpc=%h fl=%b cause=%0d pc=%h required 1 0 1 00010044 1 2 00010060",
                     is_mret, e_raised, redirect_valid, redirect_pc, flush, e_cause, e_pc);
        else pass_cnt++;
        check_flush_tail("mret");
    endtask

    task automatic test_back_to_back();
        mret_req = 1'b1; mepc_in = 32'h0001_0080;
        step();
        clear_reqs();
        step();
        // Now in FLUSH cycle 2: this ecall must be ignored.
        ecall_req = 1'b1; id_pc = 32'h0001_0090;
        step();
        clear_reqs();
        total++;
        if (e_raised !== 1'b0 || flush !== 1'b1 || redirect_valid !== 1'b0)
            $display("FAIL ecall_in_flush er=%b fl=%b rv=%b required 0 1 0", e_raised, flush, redirect_valid);
        else pass_cnt++;
        step();
        total++;
        if (flush !== 1'b0 || e_raised !== 1'b0)
            $display("FAIL flush_end fl=%b er=%b required 0 0", flush, e_raised);
        else pass_cnt++;
        ecall_req = 1'b1; id_pc = 32'h0001_0094; trap_vector_addr = 32'h0000_0300;
        step();
        clear_reqs();
        total++;
        if (e_raised !== 1'b1 || e_cause !== C_ECALL || e_tval !== 32'd0 ||
            e_pc !== 32'h0001_0094 || redirect_pc !== 32'h0000_0300 || flush !== 1'b1)
            $display("FAIL ecall_b2b er=%b cause=%0d tval=%h pc=%h rpc=%h fl=%b required 1 2 0 00010094 00000300 1",
                     e_raised, e_cause, e_tval, e_pc, redirect_pc, flush);
        else pass_cnt++;
        check_flush_tail("ecall_b2b");
    endtask

    task automatic test_reset_abort();
        illegal_req = 1'b1; id_pc = 32'h0001_00a0; id_ir = 32'h1234_5678;
        trap_vector_addr = 32'h0000_0400;
        step();
        clear_reqs();
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (flush !== 1'b0 || redirect_pc !== 32'h0001_0000 || e_raised !== 1'b0 ||
            redirect_valid !== 1'b0 || e_cause !== 2'd0)
            $display("FAIL reset_abort fl=%b rpc=%h er=%b rv=%b cause=%0d required 0 00010000 0 0 0",
                     flush, redirect_pc, e_raised, redirect_valid, e_cause);
        else pass_cnt++;
        step();
        rst_n = 1'b1;
        step();
        misalign_req = 1'b1; misalign_pc = 32'h0001_00b0; misalign_tgt = 32'h0001_00b2;
        step();
        clear_reqs();
        total++;
        if (e_raised !== 1'b1 || e_cause !== C_MISALIGN || e_pc !== 32'h0001_00b0 ||
            e_tval !== 32'h0001_00b2 || redirect_pc !== 32'h0000_0400 || flush !== 1'b1)
            $display("FAIL after_reset er=%b cause=%0d pc=%h tval=%h rpc=%h fl=%b required 1 0 000100b0 000100b2 00000400 1",
                     e_raised, e_cause, e_pc, e_tval, redirect_pc, flush);
        else pass_cnt++;
        check_flush_tail("after_reset");
    endtask

    initial begin
        test_reset();
        test_illegal();
        test_priority();
        test_mret();
        test_back_to_back();
        test_reset_abort();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
